// File: rtl/ser_feeder.sv
// ser_feeder: buffers WIDTH-bit words in a DEPTH-entry FIFO and streams them MSB-first on ser_in.
// Define SER_FEEDER_PARITY_EN to append an even-parity bit after each word's LSB.
module ser_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_in,
    output logic                     ser_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_FEEDER_PARITY_EN
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH);
`else
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr, rptr;
    logic [WIDTH-1:0] sr, sr_n, head;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ser_in_n, ser_valid_n, empty, full, push, pop;
`ifdef SER_FEEDER_PARITY_EN
    logic             par, par_n;
`endif

    assign empty      = wptr == rptr;
    assign full       = (wptr ^ rptr) == {1'b1, {PW{1'b0}}};
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign head       = mem[rptr[PW-1:0]];
    assign fifo_level = wptr - rptr;
    assign busy       = state == SHIFT || !empty;

    always_ff @(posedge clock)
        if (push) mem[wptr[PW-1:0]] <= in_data;

    // Last bit of a frame and IDLE share the load path, which gives gap-free streaming.
    always_comb begin
        state_n     = state;
        sr_n        = sr;
        cnt_n       = cnt;
        ser_in_n    = ser_in;
        ser_valid_n = ser_valid;
        pop         = 1'b0;
`ifdef SER_FEEDER_PARITY_EN
        par_n       = par;
`endif
        if (state == SHIFT && cnt != '0) begin
            sr_n  = sr << 1;
            cnt_n = cnt - 1'b1;
`ifdef SER_FEEDER_PARITY_EN
            ser_in_n = (cnt == CW'(1)) ? par : sr[WIDTH-2];
`else
            ser_in_n = sr[WIDTH-2];
`endif
        end else if (!empty) begin
            pop         = 1'b1;
            state_n     = SHIFT;
            sr_n        = head;
            cnt_n       = CNT_START;
            ser_in_n    = head[WIDTH-1];
            ser_valid_n = 1'b1;
`ifdef SER_FEEDER_PARITY_EN
            par_n       = ^head;
`endif
        end else begin
            state_n     = IDLE;
            ser_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ser_in    <= 1'b0;
            ser_valid <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
`ifdef SER_FEEDER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            ser_in    <= ser_in_n;
            ser_valid <= ser_valid_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
`ifdef SER_FEEDER_PARITY_EN
            par       <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_ser_feeder.sv
// tb_ser_feeder: randomized bench for ser_feeder against a queue-based frame model.
module tb_ser_feeder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;
`ifdef SER_FEEDER_PARITY_EN
    localparam int FR = WIDTH + 1;
    localparam logic [FR-1:0] EXP_A5 = 9'b1010_0101_0;
    localparam logic [2*FR-1:0] EXP_B2B = 18'b1111_0000_0_0000_1111_0;
`else
    localparam int FR = WIDTH;
    localparam logic [FR-1:0] EXP_A5 = 8'hA5;
    localparam logic [2*FR-1:0] EXP_B2B = 16'hF00F;
`endif

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, ser_in, ser_valid, busy;
    logic [LW-1:0] fifo_level;

    int cmps = 0;
    int fails = 0;

    ser_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_in(ser_in), .ser_valid(ser_valid), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    // Model: a queue of buffered words and a queue of bits left in the frame being presented.
    logic [WIDTH-1:0] mq[$];
    bit fr[$];
    logic [WIDTH-1:0] mw;
    bit macc;
    logic m_ser = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_ready = 1'b1;
    logic [LW-1:0] m_level = '0;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            mq.delete();
            fr.delete();
            m_ser = 1'b0;
        end else begin
            macc = in_valid && mq.size() < DEPTH;
            if (fr.size() > 0) void'(fr.pop_front());
            if (fr.size() == 0 && mq.size() > 0) begin
                mw = mq.pop_front();
                for (int i = WIDTH - 1; i >= 0; i--) fr.push_back(mw[i]);
`ifdef SER_FEEDER_PARITY_EN
                fr.push_back(^mw);
`endif
            end
            if (fr.size() > 0) m_ser = fr[0];
            if (macc) mq.push_back(in_data);
        end
        m_valid = fr.size() > 0;
        m_level = LW'(mq.size());
        m_busy  = m_valid || mq.size() > 0;
        m_ready = mq.size() < DEPTH;
    end

    logic [LW+3:0] obs, expv;
    assign obs  = {ser_valid, ser_in, busy, fifo_level, in_ready};
    assign expv = {m_valid, m_ser, m_busy, m_level, m_ready};

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        if (obs !== {1'b0, 1'b0, 1'b0, LW'(0), 1'b1}) begin fails++; $display("FAIL reset_state got=%b exp=%b", obs, {1'b0, 1'b0, 1'b0, LW'(0), 1'b1}); end
        cmps++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL reset_idle t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
        end
    endtask

    task automatic test_single;
        logic [FR-1:0] got = '0;
        int nv = 0;
        cyc(1, 8'hA5);
        for (int i = 0; i < FR; i++) begin
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL single_cyc t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) begin got = {got[FR-2:0], ser_in}; nv++; end
        end
        if (got !== EXP_A5 || nv != FR) begin fails++; $display("FAIL single_bits got=%b/%0d exp=%b/%0d", got, nv, EXP_A5, FR); end
        cmps++;
        cyc(0, '0);
        if ({ser_valid, busy} !== 2'b00) begin fails++; $display("FAIL single_end got=%b exp=00", {ser_valid, busy}); end
        cmps++;
    endtask

    task automatic test_back_to_back;
        logic [2*FR-1:0] got = '0;
        int nv = 0;
        cyc(1, 8'hF0);
        if (fifo_level !== LW'(1)) begin fails++; $display("FAIL b2b_lvl0 got=%0d exp=1", fifo_level); end
        cmps++;
        cyc(1, 8'h0F);
        if (fifo_level !== LW'(1)) begin fails++; $display("FAIL b2b_lvl1 got=%0d exp=1", fifo_level); end
        cmps++;
        for (int i = 0; i < 2 * FR; i++) begin
            if (ser_valid) begin got = {got[2*FR-2:0], ser_in}; nv++; end
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL b2b_cyc t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
        end
        if (got !== EXP_B2B || nv != 2 * FR) begin fails++; $display("FAIL b2b_bits got=%b/%0d exp=%b/%0d", got, nv, EXP_B2B, 2 * FR); end
        cmps++;
        if ({ser_valid, busy, fifo_level} !== {2'b00, LW'(0)}) begin fails++; $display("FAIL b2b_end got=%b", {ser_valid, busy, fifo_level}); end
        cmps++;
    endtask

    task automatic test_fill;
        logic [WIDTH-1:0] w[6];
        int idx = 0, nb = 0, maxl = 0;
        bit nready = 0, acc;
        for (int i = 0; i < 6; i++) w[i] = WIDTH'($urandom);
        for (int t = 0; t < 200 && idx < 6; t++) begin
            acc = in_ready;
            cyc(1, w[idx]);
            if (obs !== expv) begin fails++; $display("FAIL fill_cyc t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) nb++;
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
            if (!in_ready) nready = 1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        for (int t = 0; t < 200 && busy; t++) begin
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL fill_drain t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) nb++;
        end
        if (maxl != DEPTH || !nready || idx != 6) begin fails++; $display("FAIL fill_full maxl=%0d nready=%0d idx=%0d exp %0d/1/6", maxl, nready, idx, DEPTH); end
        cmps++;
        if (busy || nb != 6 * FR) begin fails++; $display("FAIL fill_bits busy=%0d bits=%0d exp 0/%0d", busy, nb, 6 * FR); end
        cmps++;
    endtask

    task automatic test_reset_mid;
        cyc(1, 8'h3C);
        cyc(1, WIDTH'($urandom));
        cyc(1, WIDTH'($urandom));
        cyc(0, '0);
        cyc(0, '0);
        #2 rst = 1'b1;
        #1;
        if (obs !== {1'b0, 1'b0, 1'b0, LW'(0), 1'b1}) begin fails++; $display("FAIL rstmid_async got=%b exp=%b", obs, {1'b0, 1'b0, 1'b0, LW'(0), 1'b1}); end
        cmps++;
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            cyc(0, '0);
            if ({ser_valid, busy, fifo_level} !== {2'b00, LW'(0)}) begin fails++; $display("FAIL rstmid_quiet t=%0t got=%b", $time, {ser_valid, busy, fifo_level}); end
            cmps++;
        end
    endtask

    task automatic test_push_full_pop;
        int nb = 0;
        bit rose = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(1, WIDTH'($urandom));
            if (obs !== expv) begin fails++; $display("FAIL pfp_fill t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) nb++;
        end
        in_data = WIDTH'($urandom);
        for (int t = 0; t < 3 * FR && !rose; t++) begin
            cyc(1, in_data);
            if (obs !== expv) begin fails++; $display("FAIL pfp_hold t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) nb++;
            if (in_ready) begin
                rose = 1;
                if ({fifo_level, ser_valid} !== {LW'(DEPTH - 1), 1'b1}) begin fails++; $display("FAIL pfp_pop got=%b exp=%b", {fifo_level, ser_valid}, {LW'(DEPTH - 1), 1'b1}); end
                cmps++;
            end
        end
        cyc(1, in_data);
        if (ser_valid) nb++;
        for (int t = 0; t < 200 && busy; t++) begin
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL pfp_drain t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
            if (ser_valid) nb++;
        end
        if (!rose || busy || nb != (DEPTH + 2) * FR) begin fails++; $display("FAIL pfp_bits rose=%0d busy=%0d bits=%0d exp 1/0/%0d", rose, busy, nb, (DEPTH + 2) * FR); end
        cmps++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 500; t++) begin
            cyc($urandom_range(0, 3) != 0, WIDTH'($urandom));
            if (obs !== expv) begin fails++; $display("FAIL rand_cyc t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
        end
        for (int t = 0; t < 200 && busy; t++) begin
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL rand_drain t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
        end
        if (busy) begin fails++; $display("FAIL rand_end busy=1 exp=0"); end
        cmps++;
    endtask

`ifdef SER_FEEDER_PARITY_EN
    task automatic test_parity;
        logic [17:0] got = '0;
        int nv = 0;
        cyc(1, 8'hA5);
        cyc(1, 8'h07);
        for (int i = 0; i < 18; i++) begin
            if (ser_valid) begin got = {got[16:0], ser_in}; nv++; end
            cyc(0, '0);
            if (obs !== expv) begin fails++; $display("FAIL par_cyc t=%0t got=%b exp=%b", $time, obs, expv); end
            cmps++;
        end
        if (got !== 18'b1010_0101_0_0000_0111_1 || nv != 18) begin fails++; $display("FAIL par_bits got=%b/%0d exp=%b/18", got, nv, 18'b1010_0101_0_0000_0111_1); end
        cmps++;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_fill;
        test_reset_mid;
        test_push_full_pop;
        test_random;
`ifdef SER_FEEDER_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end
endmodule
